// File: rtl/weight_load_control_unit.sv
// -----------------------------------------------------------------------------
// weight_load_control_unit
//
// Streams weight tiles from the weight memory into the shadow half of a
// double-buffered weight store that feeds a MUL_SIZE x MUL_SIZE systolic array.
// A load instruction describes a U_dim x ITER_dim weight matrix starting at
// instr_base_i. The matrix is walked as (U_dim>>5)*(ITER_dim>>5) tiles of
// MUL_SIZE contiguous rows. Each tile is read row by row, written into the
// shadow buffer, and then held until the compute side swaps to it.
//
// A second instruction may be accepted while the final tile of the current one
// is waiting in the shadow buffer. Its first tile fetch then starts right after
// the swap, with no idle cycle in between.
//
// Optional feature (compile-time macro WLOAD_PERF_CNT_EN):
//   adds starve_cycles_o, a saturating count of cycles spent fetching or
//   draining a tile while no tile is ready for the compute side.
//
// Ports:
//   clk_i, rst_i              clock (rising edge); asynchronous active-high reset
//   instr_valid_i             decoded instruction present
//   instr_load_i              instruction requests weight loading
//   instr_base_i              tile base address in weight memory
//   instr_U_dim_i             matrix U dimension
//   instr_ITER_dim_i          matrix ITER dimension
//   invalidate_instruction_o  one-cycle pulse; instruction consumed
//   wmem_rd_en_o              weight memory row read request
//   wmem_rd_addr_o            weight memory row address
//   wmem_rd_valid_i           read return strobe (in order, latency >= 1)
//   wmem_rd_data_i            read return data (one row)
//   wbuf_wr_en_o              shadow buffer row write strobe
//   wbuf_wr_row_o             shadow buffer row index
//   wbuf_wr_data_o            shadow buffer row data
//   wbuf_sel_o                which physical buffer is currently the shadow
//   compute_weights_rdy_o     complete tile in shadow buffer, not yet consumed
//   next_weight_tile_i        compute side swapped to the shadow tile
//   starve_cycles_o           (WLOAD_PERF_CNT_EN only) starvation counter
// -----------------------------------------------------------------------------
module weight_load_control_unit #(
    parameter int MUL_SIZE = 32,
    parameter int ADDR_W   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  instr_valid_i,
    input  logic                  instr_load_i,
    input  logic [ADDR_W-1:0]     instr_base_i,
    input  logic [7:0]            instr_U_dim_i,
    input  logic [7:0]            instr_ITER_dim_i,
    output logic                  invalidate_instruction_o,
    output logic                  wmem_rd_en_o,
    output logic [ADDR_W-1:0]     wmem_rd_addr_o,
    input  logic                  wmem_rd_valid_i,
    input  logic [MUL_SIZE*8-1:0] wmem_rd_data_i,
    output logic                  wbuf_wr_en_o,
    output logic [4:0]            wbuf_wr_row_o,
    output logic [MUL_SIZE*8-1:0] wbuf_wr_data_o,
    output logic                  wbuf_sel_o,
    output logic                  compute_weights_rdy_o,
    input  logic                  next_weight_tile_i
`ifdef WLOAD_PERF_CNT_EN
    ,
    output logic [31:0]           starve_cycles_o
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FULL  = 2'd3;

    localparam logic [4:0]        LAST_ROW    = 5'(MUL_SIZE - 1);
    localparam logic [ADDR_W-1:0] TILE_STRIDE = ADDR_W'(MUL_SIZE);

    logic [1:0]        state_q;
    logic [ADDR_W-1:0] tile_base_q;   // address of row 0 of the current tile
    logic [7:0]        tile_cnt_q;    // tiles in the current instruction
    logic [7:0]        tile_idx_q;    // tile currently being fetched / held
    logic [4:0]        rd_cnt_q;      // rows requested in this tile
    logic [4:0]        wr_cnt_q;      // rows returned in this tile

    // Instruction accepted while the last tile waits in FULL.
    logic              pend_q;
    logic [ADDR_W-1:0] pend_base_q;
    logic [7:0]        pend_cnt_q;

    logic [7:0] new_tiles;
    logic       instr_req;
    logic       last_tile;
    logic       accept;
    logic       accept_live;
    logic       consume;
    logic       ret_ok;
    logic       tile_done;

    assign new_tiles = (instr_U_dim_i >> 5) * (instr_ITER_dim_i >> 5);

    // An instruction being invalidated this cycle is already ours; upstream may
    // still show it as valid, so it must not be accepted a second time.
    assign instr_req = instr_valid_i & instr_load_i & ~invalidate_instruction_o;

    assign last_tile = (tile_idx_q == tile_cnt_q - 8'd1);

    assign accept = instr_req &
                    ((state_q == ST_IDLE) |
                     ((state_q == ST_FULL) & last_tile & ~pend_q));

    // Zero-tile instructions are consumed without ever starting a fetch.
    assign accept_live = accept & (new_tiles != 8'd0);

    assign consume = (state_q == ST_FULL) & next_weight_tile_i;

    // Returns are only meaningful while a tile is in flight.
    assign ret_ok = wmem_rd_valid_i & ((state_q == ST_FETCH) | (state_q == ST_DRAIN));

    assign tile_done = (state_q == ST_DRAIN) & wbuf_wr_en_o & (wbuf_wr_row_o == LAST_ROW);

    assign wmem_rd_en_o          = (state_q == ST_FETCH);
    assign wmem_rd_addr_o        = wmem_rd_en_o ? (tile_base_q + ADDR_W'(rd_cnt_q)) : '0;
    assign compute_weights_rdy_o = (state_q == ST_FULL);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order in the block.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q                  <= ST_IDLE;
            tile_base_q              <= '0;
            tile_cnt_q               <= '0;
            tile_idx_q               <= '0;
            rd_cnt_q                 <= '0;
            wr_cnt_q                 <= '0;
            pend_q                   <= 1'b0;
            pend_base_q              <= '0;
            pend_cnt_q               <= '0;
            invalidate_instruction_o <= 1'b0;
            wbuf_wr_en_o             <= 1'b0;
            wbuf_wr_row_o            <= '0;
            wbuf_wr_data_o           <= '0;
            wbuf_sel_o               <= 1'b0;
        end else begin
            invalidate_instruction_o <= accept;

            wbuf_wr_en_o <= ret_ok;
            if (ret_ok) begin
                wbuf_wr_data_o <= wmem_rd_data_i;
                wbuf_wr_row_o  <= wr_cnt_q;
                wr_cnt_q       <= wr_cnt_q + 5'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (accept_live) begin
                        tile_base_q <= instr_base_i;
                        tile_cnt_q  <= new_tiles;
                        tile_idx_q  <= '0;
                        rd_cnt_q    <= '0;
                        wr_cnt_q    <= '0;
                        state_q     <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    if (rd_cnt_q == LAST_ROW) begin
                        rd_cnt_q <= '0;
                        state_q  <= ST_DRAIN;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + 5'd1;
                    end
                end

                ST_DRAIN: begin
                    if (tile_done) begin
                        wr_cnt_q <= '0;
                        state_q  <= ST_FULL;
                    end
                end

                ST_FULL: begin
                    // Queue a new instruction only if the swap is not happening
                    // now; a simultaneous swap loads it straight into the
                    // active slot below.
                    if (accept_live && !consume) begin
                        pend_q      <= 1'b1;
                        pend_base_q <= instr_base_i;
                        pend_cnt_q  <= new_tiles;
                    end

                    if (consume) begin
                        wbuf_sel_o <= ~wbuf_sel_o;
                        tile_idx_q <= tile_idx_q + 8'd1;
                        rd_cnt_q   <= '0;
                        wr_cnt_q   <= '0;
                        if (!last_tile) begin
                            tile_base_q <= tile_base_q + TILE_STRIDE;
                            state_q     <= ST_FETCH;
                        end else if (pend_q) begin
                            tile_base_q <= pend_base_q;
                            tile_cnt_q  <= pend_cnt_q;
                            tile_idx_q  <= '0;
                            pend_q      <= 1'b0;
                            state_q     <= ST_FETCH;
                        end else if (accept_live) begin
                            tile_base_q <= instr_base_i;
                            tile_cnt_q  <= new_tiles;
                            tile_idx_q  <= '0;
                            state_q     <= ST_FETCH;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef WLOAD_PERF_CNT_EN
    // Counts cycles the compute side is waiting on an in-flight tile.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cycles_o <= '0;
        end else if (((state_q == ST_FETCH) || (state_q == ST_DRAIN)) &&
                     !compute_weights_rdy_o && (starve_cycles_o != 32'hFFFF_FFFF)) begin
            starve_cycles_o <= starve_cycles_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_weight_load_control_unit.sv
// -----------------------------------------------------------------------------
// tb_weight_load_control_unit
//
// Directed bench for weight_load_control_unit. A behavioural weight memory
// returns {16{addr}} after a programmable latency; a monitor logs every read
// request, buffer write, invalidate pulse and buffer-select toggle. All bench
// activity happens just after the falling clock edge.
// -----------------------------------------------------------------------------
module tb_weight_load_control_unit;

    localparam int MUL_SIZE = 32;
    localparam int ADDR_W   = 16;
    localparam int DW       = MUL_SIZE * 8;
    localparam int LOG_N    = 256;

    logic              clk_i;
    logic              rst_i;
    logic              instr_valid_i;
    logic              instr_load_i;
    logic [ADDR_W-1:0] instr_base_i;
    logic [7:0]        instr_U_dim_i;
    logic [7:0]        instr_ITER_dim_i;
    logic              invalidate_instruction_o;
    logic              wmem_rd_en_o;
    logic [ADDR_W-1:0] wmem_rd_addr_o;
    logic              wmem_rd_valid_i;
    logic [DW-1:0]     wmem_rd_data_i;
    logic              wbuf_wr_en_o;
    logic [4:0]        wbuf_wr_row_o;
    logic [DW-1:0]     wbuf_wr_data_o;
    logic              wbuf_sel_o;
    logic              compute_weights_rdy_o;
    logic              next_weight_tile_i;
`ifdef WLOAD_PERF_CNT_EN
    logic [31:0]       starve_cycles_o;
`endif

    weight_load_control_unit #(
        .MUL_SIZE(MUL_SIZE),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .instr_valid_i           (instr_valid_i),
        .instr_load_i            (instr_load_i),
        .instr_base_i            (instr_base_i),
        .instr_U_dim_i           (instr_U_dim_i),
        .instr_ITER_dim_i        (instr_ITER_dim_i),
        .invalidate_instruction_o(invalidate_instruction_o),
        .wmem_rd_en_o            (wmem_rd_en_o),
        .wmem_rd_addr_o          (wmem_rd_addr_o),
        .wmem_rd_valid_i         (wmem_rd_valid_i),
        .wmem_rd_data_i          (wmem_rd_data_i),
        .wbuf_wr_en_o            (wbuf_wr_en_o),
        .wbuf_wr_row_o           (wbuf_wr_row_o),
        .wbuf_wr_data_o          (wbuf_wr_data_o),
        .wbuf_sel_o              (wbuf_sel_o),
        .compute_weights_rdy_o   (compute_weights_rdy_o),
        .next_weight_tile_i      (next_weight_tile_i)
`ifdef WLOAD_PERF_CNT_EN
        ,
        .starve_cycles_o         (starve_cycles_o)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Memory model and monitor state.
    int                mem_lat = 2;
    logic              dly_v [0:7];
    logic [ADDR_W-1:0] dly_a [0:7];
    int                rd_n, wr_n, inv_n, sel_tog;
    logic              sel_prev;
    logic [ADDR_W-1:0] rd_log      [0:LOG_N-1];
    logic [4:0]        wr_row_log  [0:LOG_N-1];
    logic [DW-1:0]     wr_data_log [0:LOG_N-1];

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // Weight memory: a read requested in cycle c returns in cycle c+mem_lat.
    initial begin : mem_and_monitor
        for (int i = 0; i < 8; i++) begin
            dly_v[i] = 1'b0;
            dly_a[i] = '0;
        end
        rd_n = 0; wr_n = 0; inv_n = 0; sel_tog = 0; sel_prev = 1'b0;
        forever begin
            @(negedge clk_i);
            for (int i = 7; i > 0; i--) begin
                dly_v[i] = dly_v[i-1];
                dly_a[i] = dly_a[i-1];
            end
            dly_v[0] = wmem_rd_en_o;
            dly_a[0] = wmem_rd_addr_o;
            wmem_rd_valid_i = dly_v[mem_lat];
            wmem_rd_data_i  = dly_v[mem_lat] ? {16{dly_a[mem_lat]}} : '0;

            if (wmem_rd_en_o === 1'b1) begin
                if (rd_n < LOG_N) rd_log[rd_n] = wmem_rd_addr_o;
                rd_n++;
            end
            if (wbuf_wr_en_o === 1'b1) begin
                if (wr_n < LOG_N) begin
                    wr_row_log[wr_n]  = wbuf_wr_row_o;
                    wr_data_log[wr_n] = wbuf_wr_data_o;
                end
                wr_n++;
            end
            if (invalidate_instruction_o === 1'b1) inv_n++;
            if (wbuf_sel_o !== sel_prev) sel_tog++;
            sel_prev = wbuf_sel_o;
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic clear_logs();
        rd_n = 0; wr_n = 0; inv_n = 0; sel_tog = 0;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] base, input logic [7:0] u, input logic [7:0] it);
        instr_valid_i    = 1'b1;
        instr_load_i     = 1'b1;
        instr_base_i     = base;
        instr_U_dim_i    = u;
        instr_ITER_dim_i = it;
        tick();
        instr_valid_i    = 1'b0;
        instr_load_i     = 1'b0;
    endtask

    task automatic consume();
        next_weight_tile_i = 1'b1;
        tick();
        next_weight_tile_i = 1'b0;
    endtask

    task automatic wait_rdy(input int max_cycles);
        for (int i = 0; i < max_cycles && compute_weights_rdy_o !== 1'b1; i++) tick();
        n_cmp++;
        if (compute_weights_rdy_o !== 1'b1) begin
            n_bad++;
            $display("FAIL rdy_timeout: got rdy=%b required 1 within %0d cycles", compute_weights_rdy_o, max_cycles);
        end
    endtask

    // Checks logged reads/writes [first, first+count) against a contiguous
    // address run starting at base.
    task automatic check_stream(input string name, input int first, input int count,
                                input logic [ADDR_W-1:0] base);
        logic [ADDR_W-1:0] a;
        logic [DW-1:0]     exp_d;
        logic [4:0]        exp_r;
        for (int i = 0; i < count; i++) begin
            a     = base + ADDR_W'(i);
            exp_d = {16{a}};
            exp_r = 5'(i % MUL_SIZE);
            n_cmp++;
            if (rd_log[first+i] !== a) begin
                n_bad++;
                $display("FAIL %s_rd_addr[%0d]: got %h required %h", name, i, rd_log[first+i], a);
            end
            n_cmp++;
            if (wr_row_log[first+i] !== exp_r) begin
                n_bad++;
                $display("FAIL %s_wr_row[%0d]: got %0d required %0d", name, i, wr_row_log[first+i], exp_r);
            end
            n_cmp++;
            if (wr_data_log[first+i] !== exp_d) begin
                n_bad++;
                $display("FAIL %s_wr_data[%0d]: got %h required %h", name, i, wr_data_log[first+i], exp_d);
            end
        end
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        rst_i = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({invalidate_instruction_o, wmem_rd_en_o, wbuf_wr_en_o, wbuf_sel_o, compute_weights_rdy_o} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b required 00000",
                     {invalidate_instruction_o, wmem_rd_en_o, wbuf_wr_en_o, wbuf_sel_o, compute_weights_rdy_o});
        end
        n_cmp++;
        if ({wmem_rd_addr_o, wbuf_wr_row_o} !== 21'h0) begin
            n_bad++;
            $display("FAIL reset_addr_row: got %h/%0d required 0/0", wmem_rd_addr_o, wbuf_wr_row_o);
        end
        n_cmp++;
        if (wbuf_wr_data_o !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got %h required 0", wbuf_wr_data_o);
        end
        rst_i = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({wmem_rd_en_o, compute_weights_rdy_o, invalidate_instruction_o} !== 3'b0) begin
            n_bad++;
            $display("FAIL post_reset_idle: got %b required 000",
                     {wmem_rd_en_o, compute_weights_rdy_o, invalidate_instruction_o});
        end
    endtask

    task automatic test_single_tile();
        mem_lat = 2;
        clear_logs();
        issue(16'h0100, 8'd32, 8'd32);
        n_cmp++;
        if ({invalidate_instruction_o, wmem_rd_en_o, wmem_rd_addr_o} !== {1'b1, 1'b1, 16'h0100}) begin
            n_bad++;
            $display("FAIL single_first_cycle: got inv=%b en=%b addr=%h required 1 1 0100",
                     invalidate_instruction_o, wmem_rd_en_o, wmem_rd_addr_o);
        end
        wait_rdy(200);
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (rd_n !== 32 || wr_n !== 32 || inv_n !== 1) begin
            n_bad++;
            $display("FAIL single_counts: got rd=%0d wr=%0d inv=%0d required 32 32 1", rd_n, wr_n, inv_n);
        end
        check_stream("single", 0, 32, 16'h0100);
        n_cmp++;
        if ({compute_weights_rdy_o, wbuf_sel_o} !== 2'b10) begin
            n_bad++;
            $display("FAIL single_held: got rdy=%b sel=%b required 1 0", compute_weights_rdy_o, wbuf_sel_o);
        end
        consume();
        n_cmp++;
        if ({compute_weights_rdy_o, wbuf_sel_o, wmem_rd_en_o} !== 3'b010) begin
            n_bad++;
            $display("FAIL single_consumed: got rdy=%b sel=%b en=%b required 0 1 0",
                     compute_weights_rdy_o, wbuf_sel_o, wmem_rd_en_o);
        end
    endtask

    task automatic test_multi_tile();
        mem_lat = 3;
        clear_logs();
        issue(16'h0200, 8'd64, 8'd64);
        for (int t = 0; t < 4; t++) begin
            wait_rdy(200);
            consume();
        end
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (rd_n !== 128 || wr_n !== 128 || inv_n !== 1 || sel_tog !== 4) begin
            n_bad++;
            $display("FAIL multi_counts: got rd=%0d wr=%0d inv=%0d tog=%0d required 128 128 1 4",
                     rd_n, wr_n, inv_n, sel_tog);
        end
        check_stream("multi", 0, 128, 16'h0200);
        n_cmp++;
        if ({compute_weights_rdy_o, wmem_rd_en_o} !== 2'b00) begin
            n_bad++;
            $display("FAIL multi_idle: got rdy=%b en=%b required 0 0", compute_weights_rdy_o, wmem_rd_en_o);
        end
    endtask

    task automatic test_zero_tiles();
        mem_lat = 2;
        clear_logs();
        issue(16'h0600, 8'd16, 8'd32);
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (inv_n !== 1 || rd_n !== 0 || compute_weights_rdy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_u: got inv=%0d rd=%0d rdy=%b required 1 0 0", inv_n, rd_n, compute_weights_rdy_o);
        end
        issue(16'h0600, 8'd64, 8'd8);
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (inv_n !== 2 || rd_n !== 0) begin
            n_bad++;
            $display("FAIL zero_iter: got inv=%0d rd=%0d required 2 0", inv_n, rd_n);
        end
        // Valid instruction without the load bit is not ours to consume.
        instr_valid_i = 1'b1;
        instr_load_i  = 1'b0;
        instr_U_dim_i = 8'd32; instr_ITER_dim_i = 8'd32;
        for (int i = 0; i < 4; i++) tick();
        instr_valid_i = 1'b0;
        tick();
        n_cmp++;
        if (inv_n !== 2 || rd_n !== 0) begin
            n_bad++;
            $display("FAIL no_load_bit: got inv=%0d rd=%0d required 2 0", inv_n, rd_n);
        end
    endtask

    task automatic test_back_to_back();
        logic sel_before;
        mem_lat = 2;
        clear_logs();
        issue(16'h0300, 8'd32, 8'd32);
        wait_rdy(200);
        sel_before = wbuf_sel_o;
        // New instruction and swap in the same cycle.
        instr_valid_i      = 1'b1;
        instr_load_i       = 1'b1;
        instr_base_i       = 16'h0400;
        instr_U_dim_i      = 8'd32;
        instr_ITER_dim_i   = 8'd64;
        next_weight_tile_i = 1'b1;
        tick();
        instr_valid_i      = 1'b0;
        instr_load_i       = 1'b0;
        next_weight_tile_i = 1'b0;
        n_cmp++;
        if ({invalidate_instruction_o, wmem_rd_en_o, wmem_rd_addr_o, compute_weights_rdy_o} !==
            {1'b1, 1'b1, 16'h0400, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_no_gap: got inv=%b en=%b addr=%h rdy=%b required 1 1 0400 0",
                     invalidate_instruction_o, wmem_rd_en_o, wmem_rd_addr_o, compute_weights_rdy_o);
        end
        n_cmp++;
        if (wbuf_sel_o !== ~sel_before) begin
            n_bad++;
            $display("FAIL b2b_sel: got %b required %b", wbuf_sel_o, ~sel_before);
        end
        for (int t = 0; t < 2; t++) begin
            wait_rdy(200);
            consume();
        end
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if (rd_n !== 96 || wr_n !== 96 || inv_n !== 2 || compute_weights_rdy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_counts: got rd=%0d wr=%0d inv=%0d rdy=%b required 96 96 2 0",
                     rd_n, wr_n, inv_n, compute_weights_rdy_o);
        end
        check_stream("b2b_a", 0, 32, 16'h0300);
        check_stream("b2b_b", 32, 64, 16'h0400);
    endtask

    task automatic test_reset_mid_fetch();
        int snap_rd, snap_wr;
        mem_lat = 6;
        clear_logs();
        issue(16'h0500, 8'd32, 8'd32);
        for (int i = 0; i < 50 && !(wmem_rd_en_o === 1'b1 && wmem_rd_addr_o === 16'h050A); i++) tick();
        n_cmp++;
        if (wmem_rd_addr_o !== 16'h050A) begin
            n_bad++;
            $display("FAIL mid_reach_row10: got %h required 050a", wmem_rd_addr_o);
        end
        rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({wmem_rd_en_o, wbuf_wr_en_o, compute_weights_rdy_o, wbuf_sel_o} !== 4'b0) begin
            n_bad++;
            $display("FAIL mid_reset_immediate: got %b required 0000",
                     {wmem_rd_en_o, wbuf_wr_en_o, compute_weights_rdy_o, wbuf_sel_o});
        end
        snap_rd = rd_n;
        snap_wr = wr_n;
        tick(); tick();
        rst_i = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        n_cmp++;
        if (rd_n !== snap_rd || wr_n !== snap_wr || compute_weights_rdy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_after_reset: got rd=%0d wr=%0d rdy=%b required %0d %0d 0",
                     rd_n, wr_n, compute_weights_rdy_o, snap_rd, snap_wr);
        end
    endtask

`ifdef WLOAD_PERF_CNT_EN
    task automatic test_perf_counter();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
        mem_lat = 5;
        clear_logs();
        issue(16'h0700, 8'd32, 8'd32);
        wait_rdy(200);
        n_cmp++;
        if (starve_cycles_o !== 32'd38) begin
            n_bad++;
            $display("FAIL perf_starve: got %0d required 38", starve_cycles_o);
        end
        consume();
    endtask
`endif

    initial begin
        rst_i              = 1'b1;
        instr_valid_i      = 1'b0;
        instr_load_i       = 1'b0;
        instr_base_i       = '0;
        instr_U_dim_i      = '0;
        instr_ITER_dim_i   = '0;
        next_weight_tile_i = 1'b0;
        wmem_rd_valid_i    = 1'b0;
        wmem_rd_data_i     = '0;

        test_reset();
        test_single_tile();
        test_multi_tile();
        test_zero_tiles();
        test_back_to_back();
        test_reset_mid_fetch();
`ifdef WLOAD_PERF_CNT_EN
        test_perf_counter();
`endif
        for (int i = 0; i < 4; i++) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/weight_load_control_unit.md
WEIGHT_LOAD_CONTROL_UNIT -- requirements
Module: weight_load_control_unit

Interface
REQ-001 Parameter MUL_SIZE, default 32: systolic array dimension (rows per weight tile).
REQ-002 Parameter ADDR_W, default 16: weight memory address width.
REQ-003 clk_i  in  1  single clock; all logic on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 instr_valid_i  in  1  decoded instruction present.
REQ-006 instr_load_i  in  1  instruction requests weight loading (MAC_op[0]).
REQ-007 instr_base_i, instr_U_dim_i, instr_ITER_dim_i  in  ADDR_W / 8 / 8  tile base address and matrix dimensions.
REQ-008 invalidate_instruction_o  out  1  one-cycle pulse; instruction consumed.
REQ-009 wmem_rd_en_o, wmem_rd_addr_o  out  1 / ADDR_W  weight memory row read request.
REQ-010 wmem_rd_valid_i, wmem_rd_data_i  in  1 / MUL_SIZE*8  read return, in order, arbitrary latency >=1.
REQ-011 wbuf_wr_en_o, wbuf_wr_row_o, wbuf_wr_data_o, wbuf_sel_o  out  1 / 5 / MUL_SIZE*8 / 1  shadow weight buffer write port and buffer select.
REQ-012 compute_weights_rdy_o  out  1  complete tile in shadow buffer, not yet consumed.
REQ-013 next_weight_tile_i  in  1  compute side has swapped to the shadow tile (consume pulse).

Function
REQ-014 States: IDLE, FETCH, DRAIN, FULL; encoding free.
REQ-015 Tile count = (U_dim>>5)*(ITER_dim>>5), latched with base at acceptance; tile n row r address = base + n*MUL_SIZE + r, modulo 2^ADDR_W.
REQ-016 Acceptance: instr_valid_i & instr_load_i in IDLE, or in FULL when all tiles of the current instruction are fetched; invalidate_instruction_o pulses the following cycle.
REQ-017 Tile count 0 at acceptance: instruction invalidated, no reads, remain IDLE.
REQ-018 FETCH: wmem_rd_en_o high for exactly MUL_SIZE consecutive cycles, rows 0..MUL_SIZE-1 ascending; then DRAIN.
REQ-019 Each wmem_rd_valid_i produces, one cycle later, wbuf_wr_en_o with registered data and row = count of returns so far in this tile.
REQ-020 DRAIN -> FULL the cycle after row MUL_SIZE-1 is written; compute_weights_rdy_o rises on FULL entry.
REQ-021 FULL: on next_weight_tile_i, rdy deasserts next cycle, wbuf_sel_o toggles, tile index increments; then FETCH if tiles remain or an instruction is queued (tile 0 of new), else IDLE.
REQ-022 next_weight_tile_i outside FULL ignored; wmem_rd_valid_i in IDLE or FULL ignored (no write).
REQ-023 Simultaneous next_weight_tile_i and acceptance in FULL: both honoured; new instruction's tile 0 fetch starts next cycle.

Reset
REQ-024 rst_i asserted: state IDLE, all counters 0, wbuf_sel_o 0, every output 0, latched instruction discarded, effective immediately.
REQ-025 Returns arriving after reset release with no fetch in progress are dropped.

Configuration
REQ-026 Macro WLOAD_PERF_CNT_EN: when defined, adds output starve_cycles_o [31:0], incrementing (saturating) every cycle a tile has been requested (FETCH/DRAIN) while no tile is ready; cleared by reset. When undefined, port and counter absent; all other behaviour identical.

Verification
REQ-027 U_dim=32, ITER_dim=32, base=0x0100, 2-cycle memory -> 32 reads 0x0100..0x011F, 32 writes rows 0..31, rdy high; invalidate pulsed once.
REQ-028 U_dim=64, ITER_dim=64 (4 tiles), consume when ready -> four tiles at bases +0,+32,+64,+96, wbuf_sel_o toggles 4 times, IDLE after last consume.
REQ-029 U_dim=16 -> invalidate pulse, zero reads, rdy stays 0.
REQ-030 Second instruction presented while last tile FULL, consumed same cycle -> accepted, fetch of new base begins next cycle, no gap.
REQ-031 rst_i asserted at row 10 of FETCH, memory still returning -> no writes after reset, rdy 0, IDLE.
REQ-032 With WLOAD_PERF_CNT_EN, 5-cycle memory latency, one tile -> starve_cycles_o = 32+5+1 at rdy rise.
